image_proc_controller: RTL

Job sequencer for the image-scaling datapath. It accepts a start command with an algorithm select and rejects algorithms that are not built in. It holds the scaling datapath in reset, releases it, supervises the run with a watchdog, and waits a drain period after the datapath reports done. On success it flips the double-buffer select and pulses completion. It sits between the host/register interface and the algorithm multiplexer, and drives the multiplexer's ALGORITHM select and the datapath reset.

---
 rtl/image_proc_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/image_proc_controller.sv
// image_proc_controller: image-scaling job sequencer (start/abort/algo_sel/dp_done in; algorithm, dp_reset, busy, done, error, fb_sel, cycles out)
module image_proc_controller #(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [23:0] TIMEOUT      = 24'd1000000,
  parameter logic [3:0]  ALGO_MASK    = 4'b0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  algo_sel,
  input  logic        dp_done,
  output logic [1:0]  algorithm,
  output logic        dp_reset,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic        fb_sel,
  output logic [23:0] cycles
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, FINISH, ERR} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [23:0] cyc_inc;
  logic active;
  assign cyc_inc = (cycles == '1) ? cycles : cycles + 24'd1;
  assign active = (state == CLEAR) || (state == RUN) || (state == DRAIN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      algorithm <= '0;
      dp_reset  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= '0;
      fb_sel    <= 1'b0;
      cycles    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && active) begin
        state    <= IDLE;
        error    <= 2'd3;
        dp_reset <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: if (start && !abort) begin
            algorithm <= algo_sel;
            if (ALGO_MASK[algo_sel]) begin
              state  <= CLEAR;
              error  <= '0;
              cycles <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
            end else begin
              state <= ERR;
              error <= 2'd1;
            end
          end
          CLEAR: if (cnt == 16'(RST_CYCLES - 1)) begin
            state    <= RUN;
            dp_reset <= 1'b1;
          end else cnt <= cnt + 16'd1;
          RUN: begin
            cycles <= cyc_inc;
            // cycles is still zero only in the first RUN cycle, where done may be stale
            if (dp_done && cycles != '0) begin
              state <= DRAIN;
              cnt   <= '0;
            end else if (cyc_inc >= TIMEOUT) begin
              state    <= ERR;
              error    <= 2'd2;
              dp_reset <= 1'b0;
              busy     <= 1'b0;
            end
          end
          DRAIN: begin
            cycles <= cyc_inc;
            if (cnt == 16'(DRAIN_CYCLES - 1)) begin
              state    <= FINISH;
              done     <= 1'b1;
              fb_sel   <= ~fb_sel;
              dp_reset <= 1'b0;
              busy     <= 1'b0;
            end else cnt <= cnt + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
